uart_rx: RTL



---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sampler.sv | 59 +++++
 rtl/uart_rx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : uart_pkg                                                  |
// | Purpose    : Shared UART definitions used by the configuration block,  |
// |              the receiver and the transmitter: receiver FSM state      |
// |              encoding, parity constants, default payload width and a   |
// |              3-input majority helper.                                  |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;
   localparam logic PARITY_OFF  = 1'b0;
   localparam logic PARITY_ON   = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : uart_rx_sampler                                           |
// | Purpose    : Per-bit oversampling timer and 3-sample majority voter.   |
// |              edge_cnt runs 0..prescale-1 while run is high. Samples    |
// |              are taken at prescale/2-1 and prescale/2; the third       |
// |              sample is the live line at prescale/2+1, which is also    |
// |              the decision cycle.                                       |
// | Ports      : clk, rst_n (sync, active-low), run (frame in progress),   |
// |              rx (line), prescale (latched ratio) ->                    |
// |              bit_value (majority), bit_done (decision strobe),         |
// |              bit_end (last oversample of the bit)                      |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PSC_W = 6
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             rx,
   input  logic [PSC_W-1:0] prescale,
   output logic             bit_value,
   output logic             bit_done,
   output logic             bit_end
);

   logic [PSC_W-1:0] edge_cnt;
   logic [PSC_W-1:0] half;
   logic             sample0;
   logic             sample1;

   assign half      = prescale >> 1;
   assign bit_done  = run && (edge_cnt == half + PSC_W'(1));
   assign bit_end   = run && (edge_cnt == prescale - PSC_W'(1));
   assign bit_value = majority3(sample0, sample1, rx);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         sample0  <= 1'b1;
         sample1  <= 1'b1;
      end else begin
         // Held at 0 while idle so the first START cycle begins at 0.
         if (!run || bit_end)
            edge_cnt <= '0;
         else
            edge_cnt <= edge_cnt + PSC_W'(1);
         if (run && (edge_cnt == half - PSC_W'(1)))
            sample0 <= rx;
         if (run && (edge_cnt == half))
            sample1 <= rx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : uart_rx                                                   |
// | Purpose    : Oversampling UART receiver, 8N1/8E1/8O1 style frames,     |
// |              LSB first. Emits one-cycle data_valid / parity_error /    |
// |              stop_error pulses one cycle after the stop-bit decision.  |
// | Ports      : clk, rst_n (sync, active-low), rx_in (idle high),         |
// |              parity_enable, parity_type (0 even / 1 odd), prescale ->  |
// |              data_out, data_valid, parity_error, stop_error            |
// | Options    : UART_RX_SYNC_EN - route rx_in through a 2-flop            |
// |              synchronizer (adds 2 cycles of latency).                  |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int PRESCALE_MAX = 32
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               rx_in,
   input  logic                               parity_enable,
   input  logic                               parity_type,
   input  logic [$clog2(PRESCALE_MAX+1)-1:0]  prescale,
   output logic [DATA_WIDTH-1:0]              data_out,
   output logic                               data_valid,
   output logic                               parity_error,
   output logic                               stop_error
);

   localparam int PSC_W = $clog2(PRESCALE_MAX + 1);
   localparam int BW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   logic rx_line;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk) begin
      if (!rst_n)
         sync_q <= 2'b11;
      else
         sync_q <= {sync_q[0], rx_in};
   end
   assign rx_line = sync_q[1];
`else
   assign rx_line = rx_in;
`endif

   rx_state_e             state;
   rx_state_e             state_next;
   logic                  cfg_par_en;
   logic                  cfg_par_type;
   logic [PSC_W-1:0]      cfg_prescale;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_bad;
   logic                  bit_value;
   logic                  bit_done;
   logic                  bit_end;
   logic                  frame_done;
   logic                  exp_parity;

   uart_rx_sampler #(
      .PSC_W (PSC_W)
   ) u_sampler (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (state != IDLE),
      .rx        (rx_line),
      .prescale  (cfg_prescale),
      .bit_value (bit_value),
      .bit_done  (bit_done),
      .bit_end   (bit_end)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      frame_done = 1'b0;
      exp_parity = (^shreg) ^ (cfg_par_type == PARITY_ODD);
      case (state)
         IDLE:   if (!rx_line) state_next = START;
         // A high majority in the start bit is treated as line noise.
         START:  if (bit_done && bit_value) state_next = IDLE;
                 else if (bit_end)          state_next = DATA;
         DATA:   if (bit_end && (bit_cnt == LAST_BIT))
                    state_next = (cfg_par_en == PARITY_ON) ? PARITY : STOP;
         PARITY: if (bit_end) state_next = STOP;
         // Leave at mid-stop so a following start edge is never missed.
         STOP:   if (bit_done) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                 end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_par_en   <= PARITY_OFF;
         cfg_par_type <= PARITY_EVEN;
         cfg_prescale <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_bad      <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
         if (state == IDLE && !rx_line) begin
            cfg_par_en   <= parity_enable;
            cfg_par_type <= parity_type;
            cfg_prescale <= prescale;
         end
         case (state)
            START: begin
               bit_cnt <= '0;
               par_bad <= 1'b0;
            end
            DATA: begin
               if (bit_done) shreg[bit_cnt] <= bit_value;
               if (bit_end)  bit_cnt <= bit_cnt + BW'(1);
            end
            PARITY: begin
               if (bit_done) par_bad <= (bit_value != exp_parity);
            end
            STOP: begin
               if (frame_done) begin
                  stop_error   <= ~bit_value;
                  parity_error <= par_bad;
                  if (bit_value && !par_bad) begin
                     data_valid <= 1'b1;
                     data_out   <= shreg;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
